// File: rtl/mmio_arb_pkg.sv
// mmio_arb_pkg: shared types and constants for the two-master MMIO arbiter.
// Holds the arbiter state enum, the abort read pattern, the default
// watchdog limit and a helper that sizes the watchdog counter.
package mmio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_TIMEOUT = 255;
    localparam logic [31:0] ABORT_DATA  = 32'hDEADBEEF;

    // Watchdog counter width: wide enough to hold the limit, never below 8 bits.
    function automatic int unsigned cnt_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/mmio_req_buf.sv
// mmio_req_buf: request buffer holding the winning master's transfer while
// the slave stalls, so master-side changes during a lock are ignored.
// Ports:
//   CLK, RESET_N        clock, asynchronous active-low clear
//   load                capture d_* on the rising edge
//   d_we/d_waddr/d_be/d_din   request fields to capture
//   q_we/q_waddr/q_be/q_din   buffered request fields
module mmio_req_buf
    import mmio_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                load,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_waddr,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [DATA_W-1:0]   d_din,
    output logic                q_we,
    output logic [ADDR_W-1:0]   q_waddr,
    output logic [DATA_W/8-1:0] q_be,
    output logic [DATA_W-1:0]   q_din
);

    // Capture register with load enable.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            q_we    <= 1'b0;
            q_waddr <= '0;
            q_be    <= '0;
            q_din   <= '0;
        end else if (load) begin
            q_we    <= d_we;
            q_waddr <= d_waddr;
            q_be    <= d_be;
            q_din   <= d_din;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: round-robin arbiter sharing one MMIO slave port between
// master M0 (MCU data port) and master M1 (debug/programmer).
// Arbitration is zero-latency in IDLE; a slave stall locks the grant and
// replays the buffered request until the slave accepts. Read data returned
// by the slave one cycle after accept is steered to the winning master.
// Ports:
//   CLK, RESET_N               clock, asynchronous active-low reset
//   m{0,1}_en/we/waddr/be/din  master requests
//   m{0,1}_dout, m{0,1}_hold   master read data and stall
//   s_en/we/waddr/be/din       request forwarded to the slave
//   s_dout, s_hold             slave read data and stall
//   err                        sticky watchdog abort flag
// Build option: define MMIO_ARB_TIMEOUT_EN to enable the lock watchdog;
// otherwise a lock persists until the slave releases and err is tied 0.
module mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                m0_en,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_waddr,
    input  logic [DATA_W/8-1:0] m0_be,
    input  logic [DATA_W-1:0]   m0_din,
    output logic [DATA_W-1:0]   m0_dout,
    output logic                m0_hold,
    input  logic                m1_en,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_waddr,
    input  logic [DATA_W/8-1:0] m1_be,
    input  logic [DATA_W-1:0]   m1_din,
    output logic [DATA_W-1:0]   m1_dout,
    output logic                m1_hold,
    output logic                s_en,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_waddr,
    output logic [DATA_W/8-1:0] s_be,
    output logic [DATA_W-1:0]   s_din,
    input  logic [DATA_W-1:0]   s_dout,
    input  logic                s_hold,
    output logic                err
);

    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    logic                prio_q, prio_d;
    logic                rd_vld_q, rd_vld_d;
    logic                rd_who_q, rd_who_d;
    logic                load;
    logic                acc;
    logic                acc_rd;
    logic                acc_who;
    logic                abort;
    logic                own;
    logic                timeout_hit;
    logic [DATA_W-1:0]   rd_data;

    logic                win1;
    logic                any_req;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_waddr;
    logic [BE_W-1:0]     sel_be;
    logic [DATA_W-1:0]   sel_din;

    logic                buf_we;
    logic [ADDR_W-1:0]   buf_waddr;
    logic [BE_W-1:0]     buf_be;
    logic [DATA_W-1:0]   buf_din;

    // IDLE winner: sole requester, or the prio master when both request.
    assign any_req   = m0_en | m1_en;
    assign win1      = m1_en & (~m0_en | prio_q);
    assign sel_we    = win1 ? m1_we    : m0_we;
    assign sel_waddr = win1 ? m1_waddr : m0_waddr;
    assign sel_be    = win1 ? m1_be    : m0_be;
    assign sel_din   = win1 ? m1_din   : m0_din;

    mmio_req_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_buf (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .load    (load),
        .d_we    (sel_we),
        .d_waddr (sel_waddr),
        .d_be    (sel_be),
        .d_din   (sel_din),
        .q_we    (buf_we),
        .q_waddr (buf_waddr),
        .q_be    (buf_be),
        .q_din   (buf_din)
    );

    // State, priority pointer and read-return steering.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_who_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            rd_vld_q <= rd_vld_d;
            rd_who_q <= rd_who_d;
        end
    end

`ifdef MMIO_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             abort_rd_q;

    // Lock-cycle counter, sticky error and abort-read marker.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q      <= '0;
            err_q      <= 1'b0;
            abort_rd_q <= 1'b0;
        end else begin
            if (load) begin
                cnt_q <= '0;
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            err_q      <= err_q | abort;
            abort_rd_q <= abort & ~buf_we;
        end
    end

    // The counter equals TIMEOUT once that many lock cycles have elapsed.
    assign timeout_hit = (state_q != IDLE) && s_hold && (cnt_q == CNT_W'(TIMEOUT));
    assign err         = err_q;
    assign rd_data     = abort_rd_q ? DATA_W'(ABORT_DATA) : s_dout;
`else
    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] unused_timeout;

    assign unused_timeout = CNT_W'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
    assign rd_data        = s_dout;
`endif

    // Next-state, slave forwarding and master hold generation.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        load     = 1'b0;
        acc      = 1'b0;
        acc_rd   = 1'b0;
        acc_who  = 1'b0;
        abort    = 1'b0;
        own      = (state_q == LOCK1);
        s_en     = 1'b0;
        s_we     = 1'b0;
        s_waddr  = '0;
        s_be     = '0;
        s_din    = '0;
        m0_hold  = 1'b0;
        m1_hold  = 1'b0;
        rd_vld_d = 1'b0;
        rd_who_d = 1'b0;

        // Outputs are forced to the no-request values while reset is low.
        if (RESET_N) begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        s_en    = 1'b1;
                        s_we    = sel_we;
                        s_waddr = sel_waddr;
                        s_be    = sel_be;
                        s_din   = sel_din;
                        m0_hold = m0_en & (win1 | s_hold);
                        m1_hold = m1_en & (~win1 | s_hold);
                        if (s_hold) begin
                            load    = 1'b1;
                            state_d = win1 ? LOCK1 : LOCK0;
                        end else begin
                            acc     = 1'b1;
                            acc_who = win1;
                            acc_rd  = ~sel_we;
                            prio_d  = ~win1;
                        end
                    end
                end
                LOCK0, LOCK1: begin
                    if (timeout_hit) begin
                        // Forced abort: release the owner without an accept.
                        abort   = 1'b1;
                        state_d = IDLE;
                        prio_d  = ~own;
                        m0_hold = m0_en & own;
                        m1_hold = m1_en & ~own;
                    end else begin
                        s_en    = 1'b1;
                        s_we    = buf_we;
                        s_waddr = buf_waddr;
                        s_be    = buf_be;
                        s_din   = buf_din;
                        m0_hold = m0_en & (own | s_hold);
                        m1_hold = m1_en & (~own | s_hold);
                        if (!s_hold) begin
                            acc     = 1'b1;
                            acc_who = own;
                            acc_rd  = ~buf_we;
                            prio_d  = ~own;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            rd_vld_d = (acc & acc_rd) | (abort & ~buf_we);
            rd_who_d = acc ? acc_who : own;
        end
    end

    // Read data is visible only on the master that won the read.
    assign m0_dout = (rd_vld_q && !rd_who_q) ? rd_data : '0;
    assign m1_dout = (rd_vld_q &&  rd_who_q) ? rd_data : '0;

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: directed self-checking bench for mmio_arbiter.
// The bench plays both masters and the slave; expected values are
// hand-computed per scenario. With MMIO_ARB_TIMEOUT_EN the DUT is built
// with TIMEOUT=4 and the watchdog scenario is added.
module tb_mmio_arbiter;

`ifdef MMIO_ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        CLK;
    logic        RESET_N;
    logic        m0_en, m0_we, m1_en, m1_we;
    logic [29:0] m0_waddr, m1_waddr;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_din, m1_din, m0_dout, m1_dout;
    logic        m0_hold, m1_hold;
    logic        s_en, s_we;
    logic [29:0] s_waddr;
    logic [3:0]  s_be;
    logic [31:0] s_din, s_dout;
    logic        s_hold;
    logic        err;

    int vectors;
    int miscompares;

    mmio_arbiter #(
        .ADDR_W  (30),
        .DATA_W  (32),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .m0_en    (m0_en),
        .m0_we    (m0_we),
        .m0_waddr (m0_waddr),
        .m0_be    (m0_be),
        .m0_din   (m0_din),
        .m0_dout  (m0_dout),
        .m0_hold  (m0_hold),
        .m1_en    (m1_en),
        .m1_we    (m1_we),
        .m1_waddr (m1_waddr),
        .m1_be    (m1_be),
        .m1_din   (m1_din),
        .m1_dout  (m1_dout),
        .m1_hold  (m1_hold),
        .s_en     (s_en),
        .s_we     (s_we),
        .s_waddr  (s_waddr),
        .s_be     (s_be),
        .s_din    (s_din),
        .s_dout   (s_dout),
        .s_hold   (s_hold),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        m0_en = 1'b0; m0_we = 1'b0; m0_waddr = '0; m0_be = '0; m0_din = '0;
        m1_en = 1'b0; m1_we = 1'b0; m1_waddr = '0; m1_be = '0; m1_din = '0;
        s_dout = '0; s_hold = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        clear_inputs();
        RESET_N = 1'b0;
        #2;
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        RESET_N = 1'b0;
        #3;
        vectors++; if (s_en !== 1'b0) begin miscompares++; $display("FAIL rst_s_en got %0h exp 0", s_en); end
        vectors++; if (m0_hold !== 1'b0 || m1_hold !== 1'b0) begin miscompares++; $display("FAIL rst_hold got %0h%0h exp 00", m0_hold, m1_hold); end
        vectors++; if (m0_dout !== 32'h0 || m1_dout !== 32'h0) begin miscompares++; $display("FAIL rst_dout got %h %h exp 0 0", m0_dout, m1_dout); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %0h exp 0", err); end
        step();
        RESET_N = 1'b1;
        #2;
        vectors++; if (s_en !== 1'b0 || s_waddr !== 30'h0 || s_din !== 32'h0) begin miscompares++; $display("FAIL idle_s got en=%0h a=%h d=%h exp 0", s_en, s_waddr, s_din); end
        step();
    endtask

    task automatic test_single_write();
        m0_en = 1'b1; m0_we = 1'b1; m0_waddr = 30'h0442_0000; m0_be = 4'b0011; m0_din = 32'h0000_A5A5;
        s_hold = 1'b0;
        #2;
        vectors++; if (s_en !== 1'b1 || s_we !== 1'b1) begin miscompares++; $display("FAIL wr_en_we got %0h%0h exp 11", s_en, s_we); end
        vectors++; if (s_waddr !== 30'h0442_0000) begin miscompares++; $display("FAIL wr_waddr got %h exp 04420000", s_waddr); end
        vectors++; if (s_be !== 4'b0011) begin miscompares++; $display("FAIL wr_be got %b exp 0011", s_be); end
        vectors++; if (s_din !== 32'h0000_A5A5) begin miscompares++; $display("FAIL wr_din got %h exp 0000a5a5", s_din); end
        vectors++; if (m0_hold !== 1'b0 || m1_hold !== 1'b0) begin miscompares++; $display("FAIL wr_hold got %0h%0h exp 00", m0_hold, m1_hold); end
        step();
        clear_inputs();
        #2;
        vectors++; if (s_en !== 1'b0 || m0_dout !== 32'h0) begin miscompares++; $display("FAIL wr_after got en=%0h dout=%h exp 0 0", s_en, m0_dout); end
        step();
    endtask

    task automatic test_both_read();
        do_reset();
        m0_en = 1'b1; m0_we = 1'b0; m0_waddr = 30'h10; m0_be = 4'hF;
        m1_en = 1'b1; m1_we = 1'b0; m1_waddr = 30'h20; m1_be = 4'hF;
        #2;
        vectors++; if (s_waddr !== 30'h10 || s_we !== 1'b0) begin miscompares++; $display("FAIL rd0_addr got %h we=%0h exp 10 0", s_waddr, s_we); end
        vectors++; if (m0_hold !== 1'b0 || m1_hold !== 1'b1) begin miscompares++; $display("FAIL rd0_hold got %0h%0h exp 01", m0_hold, m1_hold); end
        step();
        m0_en = 1'b0;
        s_dout = 32'h1111_0000;
        #2;
        vectors++; if (m0_dout !== 32'h1111_0000 || m1_dout !== 32'h0) begin miscompares++; $display("FAIL rd0_dout got %h %h exp 11110000 0", m0_dout, m1_dout); end
        vectors++; if (s_waddr !== 30'h20 || m1_hold !== 1'b0) begin miscompares++; $display("FAIL rd1_grant got %h hold=%0h exp 20 0", s_waddr, m1_hold); end
        step();
        m1_en = 1'b0;
        s_dout = 32'h2222_0000;
        #2;
        vectors++; if (m1_dout !== 32'h2222_0000 || m0_dout !== 32'h0) begin miscompares++; $display("FAIL rd1_dout got %h %h exp 0 22220000", m0_dout, m1_dout); end
        step();
        #2;
        vectors++; if (m1_dout !== 32'h0) begin miscompares++; $display("FAIL rd1_once got %h exp 0", m1_dout); end
        step();
    endtask

    task automatic test_hold_lock();
        // Single M0 write moves the pointer to M1.
        m0_en = 1'b1; m0_we = 1'b1; m0_waddr = 30'h5; m0_din = 32'h5; m0_be = 4'hF;
        step();
        m0_we = 1'b0; m0_waddr = 30'h40;
        m1_en = 1'b1; m1_we = 1'b1; m1_waddr = 30'h30; m1_be = 4'b1100; m1_din = 32'h0000_AAAA;
        s_hold = 1'b1;
        #2;
        vectors++; if (s_waddr !== 30'h30 || s_din !== 32'h0000_AAAA) begin miscompares++; $display("FAIL hl_c1 got %h %h exp 30 0000aaaa", s_waddr, s_din); end
        vectors++; if (m0_hold !== 1'b1 || m1_hold !== 1'b1) begin miscompares++; $display("FAIL hl_c1_hold got %0h%0h exp 11", m0_hold, m1_hold); end
        step();
        m1_din = 32'h0000_BBBB; m1_waddr = 30'h31; m1_be = 4'b0001;
        for (int c = 2; c <= 3; c++) begin
            #2;
            vectors++; if (s_en !== 1'b1 || s_din !== 32'h0000_AAAA || s_waddr !== 30'h30 || s_be !== 4'b1100) begin miscompares++; $display("FAIL hl_lock_c%0d got en=%0h a=%h d=%h be=%b exp 1 30 0000aaaa 1100", c, s_en, s_waddr, s_din, s_be); end
            vectors++; if (m0_hold !== 1'b1 || m1_hold !== 1'b1) begin miscompares++; $display("FAIL hl_hold_c%0d got %0h%0h exp 11", c, m0_hold, m1_hold); end
            step();
        end
        s_hold = 1'b0;
        #2;
        vectors++; if (s_din !== 32'h0000_AAAA || m1_hold !== 1'b0 || m0_hold !== 1'b1) begin miscompares++; $display("FAIL hl_c4 got d=%h h=%0h%0h exp 0000aaaa 10", s_din, m0_hold, m1_hold); end
        step();
        m1_we = 1'b0; m1_waddr = 30'h50;
        #2;
        vectors++; if (s_waddr !== 30'h40 || m0_hold !== 1'b0 || m1_hold !== 1'b1) begin miscompares++; $display("FAIL hl_prio got %h h=%0h%0h exp 40 01", s_waddr, m0_hold, m1_hold); end
        step();
        clear_inputs();
        s_dout = 32'hCAFE_0040;
        #2;
        vectors++; if (m0_dout !== 32'hCAFE_0040 || m1_dout !== 32'h0) begin miscompares++; $display("FAIL hl_rd got %h %h exp cafe0040 0", m0_dout, m1_dout); end
        step();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        m0_en = 1'b1; m0_we = 1'b0; m0_waddr = 30'h77;
        s_hold = 1'b1;
        step();
        #2;
        vectors++; if (s_en !== 1'b1 || m0_hold !== 1'b1) begin miscompares++; $display("FAIL rml_lock got %0h %0h exp 1 1", s_en, m0_hold); end
        RESET_N = 1'b0;
        #1;
        vectors++; if (s_en !== 1'b0 || m0_hold !== 1'b0 || s_waddr !== 30'h0) begin miscompares++; $display("FAIL rml_async got en=%0h h=%0h a=%h exp 0 0 0", s_en, m0_hold, s_waddr); end
        RESET_N = 1'b1;
        s_hold = 1'b0;
        m0_waddr = 30'h55;
        m1_en = 1'b1; m1_waddr = 30'h66;
        #1;
        vectors++; if (s_waddr !== 30'h55 || m0_hold !== 1'b0 || m1_hold !== 1'b1) begin miscompares++; $display("FAIL rml_idle got %h h=%0h%0h exp 55 01", s_waddr, m0_hold, m1_hold); end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_alternate();
        logic e0, e1;
        do_reset();
        m0_en = 1'b1; m0_we = 1'b1; m0_waddr = 30'h1;
        m1_en = 1'b1; m1_we = 1'b1; m1_waddr = 30'h2;
        for (int i = 0; i < 20; i++) begin
            e0 = (i % 2) == 1;
            e1 = (i % 2) == 0;
            #2;
            vectors++; if (m0_hold !== e0 || m1_hold !== e1) begin miscompares++; $display("FAIL alt_c%0d got %0h%0h exp %0h%0h", i, m0_hold, m1_hold, e0, e1); end
            step();
        end
        clear_inputs();
        step();
    endtask

`ifdef MMIO_ARB_TIMEOUT_EN
    task automatic test_watchdog();
        do_reset();
        m0_en = 1'b1; m0_we = 1'b0; m0_waddr = 30'h60;
        s_hold = 1'b1;
        #2;
        vectors++; if (m0_hold !== 1'b1) begin miscompares++; $display("FAIL wd_idle got %0h exp 1", m0_hold); end
        step();
        for (int k = 0; k < 4; k++) begin
            #2;
            vectors++; if (m0_hold !== 1'b1 || s_en !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL wd_lock%0d got h=%0h en=%0h err=%0h exp 1 1 0", k, m0_hold, s_en, err); end
            step();
        end
        #2;
        vectors++; if (m0_hold !== 1'b0 || s_en !== 1'b0) begin miscompares++; $display("FAIL wd_abort got h=%0h en=%0h exp 0 0", m0_hold, s_en); end
        step();
        m0_en = 1'b0; s_hold = 1'b0; s_dout = 32'h0000_1234;
        #2;
        vectors++; if (m0_dout !== 32'hDEAD_BEEF || err !== 1'b1) begin miscompares++; $display("FAIL wd_dout got %h err=%0h exp deadbeef 1", m0_dout, err); end
        m1_en = 1'b1; m1_we = 1'b1; m1_waddr = 30'h3;
        step();
        m1_en = 1'b0;
        #2;
        vectors++; if (err !== 1'b1 || m0_dout !== 32'h0) begin miscompares++; $display("FAIL wd_sticky got err=%0h dout=%h exp 1 0", err, m0_dout); end
        step();
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single_write();
        test_both_read();
        test_hold_lock();
        test_reset_mid_lock();
        test_alternate();
`ifdef MMIO_ARB_TIMEOUT_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-master arbiter sharing the single memory-mapped IO slave port (the board peripheral decoder: LEDs, seven-segment, switches, cycle counter) between the MCU data port (M0) and a second bus master (M1, debug/programmer access). It sits between the masters and the MMIO decoder in the wrapper clock domain (sclk). It grants the port round-robin, locks the grant while the slave holds, and steers registered read data back to the winning master. An optional watchdog aborts transfers the slave holds too long.

## Interface
- ADDR_W, 30, word address width (byte address = {waddr, 2'b00})
- DATA_W, 32, data width; be width = DATA_W/8
- TIMEOUT, 255, max slave-hold cycles before abort (watchdog build only)

- CLK  in  1  MCU clock; all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- m0_en, m1_en  in  1  master request
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_waddr, m1_waddr  in  ADDR_W  word address
- m0_be, m1_be  in  4  byte enables
- m0_din, m1_din  in  DATA_W  write data
- m0_dout, m1_dout  out  DATA_W  read data, valid the cycle after read accept
- m0_hold, m1_hold  out  1  stall; master keeps request stable while 1
- s_en, s_we, s_waddr, s_be, s_din  out  —  request forwarded to the slave
- s_dout  in  DATA_W  slave read data, registered by the slave at accept edge
- s_hold  in  1  slave stall
- err  out  1  sticky watchdog abort flag

## Operation
- States: IDLE, LOCK0, LOCK1. 1-bit priority pointer `prio` (reset 0 = M0 preferred).
- IDLE: winner = sole requester; if both request, winner = prio. Winner's fields forwarded combinationally to s_*. s_hold=0 → accept, prio ← other master, stay IDLE. s_hold=1 → latch winner's we/waddr/be/din into a request buffer, go LOCKwinner.
- LOCKx: s_* driven from the request buffer (s_en=1), so master-side changes are ignored. s_hold=0 → accept, prio ← other, return to IDLE. New requests are not arbitrated until IDLE.
- Holds: mX_hold=0 when mX_en=0. Loser or non-owner with en=1 → hold=1. Winner/owner → hold=s_hold.
- Accept = cycle with s_en=1 and s_hold=0. Exactly one master sees en=1, hold=0 that cycle.
- Read return: on accepted read, `rd_sel` ← winner, else none. Next cycle m[rd_sel]_dout = s_dout. The other dout is 0.
- No requests: all s_* = 0.
- Reset (any time, including mid-LOCK): state IDLE, prio 0, rd_sel none, buffer 0, err 0, counter 0. Outputs go to the no-request values immediately (async).

## Timing
- Arbitration is zero-latency. A write to an idle, non-holding slave completes in the request cycle.
- Read data appears 1 cycle after accept, for one cycle only.
- Back-to-back accepts every cycle are supported. Alternating contention gives each master 50 % throughput.
- Hold on the forwarded request: latency = 1 + hold cycles. The buffer captures at the edge leaving IDLE.

## Configuration
- MMIO_ARB_TIMEOUT_EN defined: an 8+-bit counter clears on LOCK entry and increments each LOCK cycle. When it reaches TIMEOUT with s_hold still 1:
  - forced abort: owner hold=0, s_en=0 that cycle, return to IDLE, err ← 1 (sticky until reset);
  - if aborted request was a read, owner dout = 32'hDEADBEEF next cycle.
- Undefined: no counter. LOCK persists indefinitely. err tied 0.

## Structure
- Shared package mmio_arb_pkg: state enum (IDLE, LOCK0, LOCK1), ABORT_DATA = 32'hDEADBEEF, default TIMEOUT.
- One sub-module, mmio_req_buf: request buffer (we/waddr/be/din registers with load enable and async clear).
- Arbiter FSM, prio, rd_sel and watchdog stay in mmio_arbiter.

## Test plan
- M0 write 0x11080000 data 0x0000A5A5 be 4'b0011, slave no hold → s_* mirrors M0 same cycle, m0_hold=0, m1 idle.
- Both read same cycle after reset → M0 accepted first (m1_hold=1), M1 next cycle. m0_dout then m1_dout each return s_dout one cycle after their accept.
- Slave holds 3 cycles on M1 write; M1 changes din mid-hold → s_din stays at the latched value; m0 held for all 4 cycles; prio→M0 after.
- Assert RESET_N=0 during LOCK0 → s_en=0 and m0_hold=0 asynchronously; after release, state IDLE, prio M0.
- With MMIO_ARB_TIMEOUT_EN, TIMEOUT=4, slave holds forever on M0 read → abort after 4 LOCK cycles, err=1, m0_dout=0xDEADBEEF next cycle, err stays 1 through later good transfers.
- Continuous requests from both for 20 cycles, no hold → grants alternate exactly; no cycle with two accepts.
